// File: rtl/systolic_feeder_if.sv
// Load bus and array-edge signals of the systolic feeder.
// master = operand loader / array side, slave = the feeder itself.
interface systolic_feeder_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_a;
    logic [N*DW-1:0] in_b;
    logic            arr_clr_n;
    logic [N*DW-1:0] a_out;
    logic [N*DW-1:0] b_out;
    logic            busy;
    logic            done;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, arr_clr_n, a_out, b_out, busy, done
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, arr_clr_n, a_out, b_out, busy, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers one NxN operand pair, clears the MAC array, then streams skewed,
// zero-padded A rows (west edge) and B columns (north edge) into it.
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst,
    systolic_feeder_if.slave   bus
);
    localparam int CW = $clog2(3 * N);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] N_C    = CW'(N);
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);
    localparam logic [CW-1:0] C_LAST = CW'(3 * N - 3);

    typedef enum logic [1:0] {S_LOAD, S_CLEAR, S_STREAM, S_DONE} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            arr_clr_n_reg;
    logic            done_reg;
    logic [N*DW-1:0] a_out_reg;
    logic [N*DW-1:0] b_out_reg;

    // a_buf[k] holds column k of A, b_buf[k] holds row k of B
    logic [N*DW-1:0] a_buf [N];
    logic [N*DW-1:0] b_buf [N];

    logic            accept;
    logic [CW-1:0]   c_next;
    logic [N*DW-1:0] a_next;
    logic [N*DW-1:0] b_next;

    assign accept = bus.in_valid && (state_reg == S_LOAD);

    always_ff @(posedge clk) begin
        if (accept) begin
            a_buf[cnt_reg[IW-1:0]] <= bus.in_a;
            b_buf[cnt_reg[IW-1:0]] <= bus.in_b;
        end
    end

    // Outputs are registered, so lanes are prepared for the stream cycle
    // that begins at the coming edge.
    assign c_next = (state_reg == S_CLEAR) ? '0 : cnt_reg + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [CW:0] diff;
            logic        hit;
            assign diff = {1'b0, c_next} - {1'b0, CW'(gi)};
            assign hit  = !diff[CW] && (diff[CW-1:0] < N_C);
            // lane gi carries A[gi][c-gi] and B[c-gi][gi]: same slot index
            assign a_next[gi*DW +: DW] = hit ? a_buf[diff[IW-1:0]][gi*DW +: DW] : '0;
            assign b_next[gi*DW +: DW] = hit ? b_buf[diff[IW-1:0]][gi*DW +: DW] : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_LOAD;
            cnt_reg       <= '0;
            arr_clr_n_reg <= 1'b1;
            done_reg      <= 1'b0;
            a_out_reg     <= '0;
            b_out_reg     <= '0;
        end else begin
            case (state_reg)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        if (cnt_reg == K_LAST) begin
                            state_reg     <= S_CLEAR;
                            cnt_reg       <= '0;
                            arr_clr_n_reg <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    state_reg     <= S_STREAM;
                    cnt_reg       <= '0;
                    arr_clr_n_reg <= 1'b1;
                    a_out_reg     <= a_next;
                    b_out_reg     <= b_next;
                end
                S_STREAM: begin
                    if (cnt_reg == C_LAST) begin
                        state_reg <= S_DONE;
                        cnt_reg   <= '0;
                        done_reg  <= 1'b1;
                        a_out_reg <= '0;
                        b_out_reg <= '0;
                    end else begin
                        cnt_reg   <= c_next;
                        a_out_reg <= a_next;
                        b_out_reg <= b_next;
                    end
                end
                S_DONE: begin
                    state_reg <= S_LOAD;
                    cnt_reg   <= '0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_LOAD;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == S_LOAD);
    assign bus.busy      = (state_reg != S_LOAD);
    assign bus.arr_clr_n = arr_clr_n_reg;
    assign bus.done      = done_reg;
    assign bus.a_out     = a_out_reg;
    assign bus.b_out     = b_out_reg;
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: drives operand jobs into the feeder, feeds its
// edge streams into a behavioural 4x4 MAC grid and compares with A*B.
module tb_systolic_feeder;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int NC = 3 * N - 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_feeder_if #(.N(N), .DW(DW)) ifc ();
    systolic_feeder #(.N(N), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(ifc));

    // Behavioural MAC array: a moves east, b moves south, one cycle per PE.
    logic signed [DW-1:0] ga [N][N];
    logic signed [DW-1:0] gb [N][N];
    logic signed [DW-1:0] pa [N][N];
    logic signed [DW-1:0] pb [N][N];
    logic signed [15:0]   prod [N][N];
    logic [15:0]          acc [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ga[i][0] = ifc.a_out[i*DW +: DW];
            gb[0][i] = ifc.b_out[i*DW +: DW];
            for (int j = 1; j < N; j++) begin
                ga[i][j] = pa[i][j-1];
                gb[j][i] = pb[j-1][i];
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                prod[i][j] = ga[i][j] * gb[i][j];
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                pa[i][j]  <= ga[i][j];
                pb[i][j]  <= gb[i][j];
                acc[i][j] <= (!ifc.arr_clr_n) ? 16'h0000 : acc[i][j] + prod[i][j];
            end
    end

    logic signed [DW-1:0] am [N][N];
    logic signed [DW-1:0] bm [N][N];
    logic [15:0]          exp_c [N][N];
    logic [15:0]          obs_c [N][N];
    logic [N*DW-1:0]      obs_a [NC];
    logic [N*DW-1:0]      obs_b [NC];
    int done_t, clr_cnt, ready_hi, busy_lo, load_cyc, ready_lo_load;
    int checks = 0;
    int errors = 0;

    task automatic compute_exp();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int s = 0;
                for (int k = 0; k < N; k++) s += int'(am[i][k]) * int'(bm[k][j]);
                exp_c[i][j] = 16'(s);
            end
    endtask

    function automatic logic [DW-1:0] exp_a_lane(input int c, input int i);
        int k = c - i;
        if (k >= 0 && k < N) return am[i][k];
        return '0;
    endfunction

    function automatic logic [DW-1:0] exp_b_lane(input int c, input int j);
        int k = c - j;
        if (k >= 0 && k < N) return bm[k][j];
        return '0;
    endfunction

    task automatic randomize_ops();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = DW'($urandom);
                bm[i][j] = DW'($urandom);
            end
    endtask

    // mode 0: continuous valid, 1: valid every third cycle, 2: valid held always
    task automatic load_only(input int mode);
        int beat = 0;
        load_cyc = 0;
        ready_lo_load = 0;
        while (beat < N && load_cyc < 200) begin
            @(negedge clk);
            if (mode == 1 && (load_cyc % 3) != 0) begin
                ifc.in_valid = 1'b0;
                ifc.in_a = $urandom;
                ifc.in_b = $urandom;
            end else begin
                ifc.in_valid = 1'b1;
                for (int i = 0; i < N; i++) begin
                    ifc.in_a[i*DW +: DW] = am[i][beat];
                    ifc.in_b[i*DW +: DW] = bm[beat][i];
                end
            end
            if (!ifc.in_ready) ready_lo_load++;
            if (ifc.in_valid && ifc.in_ready) beat++;
            load_cyc++;
        end
    endtask

    // t counts cycles after the last accept edge: 1=CLEAR, 2..3N-1=STREAM
    task automatic run_job(input int mode);
        int t = 0;
        load_only(mode);
        done_t = -1; clr_cnt = 0; ready_hi = 0; busy_lo = 0;
        for (int c = 0; c < NC; c++) begin obs_a[c] = 'x; obs_b[c] = 'x; end
        while (done_t < 0 && t < 40) begin
            @(negedge clk);
            t++;
            ifc.in_valid = (mode == 2);
            ifc.in_a = $urandom;
            ifc.in_b = $urandom;
            if (!ifc.arr_clr_n) clr_cnt++;
            if (ifc.in_ready) ready_hi++;
            if (!ifc.busy) busy_lo++;
            if (t >= 2 && t <= 3 * N - 1) begin
                obs_a[t-2] = ifc.a_out;
                obs_b[t-2] = ifc.b_out;
            end
            if (ifc.done) begin
                done_t = t;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) obs_c[i][j] = acc[i][j];
            end
        end
    endtask

    task automatic test_reset();
        ifc.in_valid = 1'b0; ifc.in_a = '0; ifc.in_b = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (ifc.in_ready !== 1'b1) begin $display("FAIL reset_in_ready phase %0d got %b want 1", p, ifc.in_ready); errors++; end
            checks++;
            if (ifc.busy !== 1'b0) begin $display("FAIL reset_busy phase %0d got %b want 0", p, ifc.busy); errors++; end
            checks++;
            if (ifc.done !== 1'b0) begin $display("FAIL reset_done phase %0d got %b want 0", p, ifc.done); errors++; end
            checks++;
            if (ifc.arr_clr_n !== 1'b1) begin $display("FAIL reset_clr_n phase %0d got %b want 1", p, ifc.arr_clr_n); errors++; end
            checks++;
            if (ifc.a_out !== '0 || ifc.b_out !== '0) begin
                $display("FAIL reset_outs phase %0d got a=%h b=%h want 0", p, ifc.a_out, ifc.b_out); errors++;
            end
            checks++;
            rst = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_identity();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                am[i][k] = DW'(4 * i + k + 1);
                bm[i][k] = (i == k) ? 8'd1 : 8'd0;
            end
        run_job(0);
        for (int c = 0; c < NC; c++) begin
            logic [DW-1:0] want_a;
            want_a = (c >= 2 && c <= 5) ? DW'(c + 7) : '0;
            if (obs_a[c][2*DW +: DW] !== want_a) begin
                $display("FAIL ident_a_lane2 c=%0d got %0d want %0d", c, obs_a[c][2*DW +: DW], want_a); errors++;
            end
            checks++;
            for (int j = 0; j < N; j++) begin
                if (obs_b[c][j*DW +: DW] !== ((c == 2 * j) ? 8'd1 : 8'd0)) begin
                    $display("FAIL ident_b c=%0d lane %0d got %0d", c, j, obs_b[c][j*DW +: DW]); errors++;
                end
                checks++;
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (obs_c[i][j] !== 16'(4 * i + j + 1)) begin
                    $display("FAIL ident_c[%0d][%0d] got %0d want %0d", i, j, obs_c[i][j], 4 * i + j + 1); errors++;
                end
                checks++;
            end
        if (done_t !== 12) begin $display("FAIL ident_done_lat got %0d want 12", done_t); errors++; end
        checks++;
        if (clr_cnt !== 1) begin $display("FAIL ident_clr_pulses got %0d want 1", clr_cnt); errors++; end
        checks++;
        if (ready_hi !== 0 || busy_lo !== 0) begin
            $display("FAIL ident_busy_ready ready_hi=%0d busy_lo=%0d want 0 0", ready_hi, busy_lo); errors++;
        end
        checks++;
    endtask

    task automatic test_gapped();
        run_job(1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (obs_c[i][j] !== 16'(4 * i + j + 1)) begin
                    $display("FAIL gap_c[%0d][%0d] got %0d want %0d", i, j, obs_c[i][j], 4 * i + j + 1); errors++;
                end
                checks++;
            end
        if (load_cyc !== 10) begin $display("FAIL gap_load_cycles got %0d want 10", load_cyc); errors++; end
        checks++;
        if (ready_lo_load !== 0 || ready_hi !== 0) begin
            $display("FAIL gap_in_ready low_in_load=%0d high_while_busy=%0d want 0 0", ready_lo_load, ready_hi); errors++;
        end
        checks++;
        if (done_t !== 12) begin $display("FAIL gap_done_lat got %0d want 12", done_t); errors++; end
        checks++;
    endtask

    task automatic test_held_valid();
        for (int job = 0; job < 2; job++) begin
            randomize_ops();
            compute_exp();
            run_job(2);
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    if (obs_c[i][j] !== exp_c[i][j]) begin
                        $display("FAIL held_c job %0d [%0d][%0d] got %h want %h", job, i, j, obs_c[i][j], exp_c[i][j]); errors++;
                    end
                    checks++;
                end
            if (load_cyc !== N) begin $display("FAIL held_beats job %0d got %0d cycles want %0d", job, load_cyc, N); errors++; end
            checks++;
            if (clr_cnt !== 1) begin $display("FAIL held_clr_pulses job %0d got %0d want 1", job, clr_cnt); errors++; end
            checks++;
            if (ready_hi !== 0) begin $display("FAIL held_ready_busy job %0d got %0d want 0", job, ready_hi); errors++; end
            checks++;
        end
        ifc.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin am[i][j] = 8'sd1; bm[i][j] = 8'sd1; end
        run_job(0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (obs_c[i][j] !== 16'd4) begin $display("FAIL b2b_ones_c[%0d][%0d] got %0d want 4", i, j, obs_c[i][j]); errors++; end
                checks++;
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = (i == j) ? 8'sd1 : 8'sd0;
                bm[i][j] = (i == j) ? 8'sd1 : 8'sd0;
            end
        run_job(0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (obs_c[i][j] !== ((i == j) ? 16'd1 : 16'd0)) begin
                    $display("FAIL b2b_ident_c[%0d][%0d] got %0d want %0d", i, j, obs_c[i][j], (i == j)); errors++;
                end
                checks++;
            end
        if (load_cyc !== N) begin $display("FAIL b2b_restart got %0d load cycles want %0d", load_cyc, N); errors++; end
        checks++;
    endtask

    task automatic test_signed();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin am[i][j] = -8'sd128; bm[i][j] = -8'sd128; end
        run_job(0);
        if (obs_a[0][DW-1:0] !== 8'h80 || obs_b[0][DW-1:0] !== 8'h80) begin
            $display("FAIL signed_lane80 got a=%h b=%h want 80 80", obs_a[0][DW-1:0], obs_b[0][DW-1:0]); errors++;
        end
        checks++;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (obs_c[i][j] !== 16'h0000) begin $display("FAIL signed_m128_c[%0d][%0d] got %h want 0000", i, j, obs_c[i][j]); errors++; end
                checks++;
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin am[i][j] = -8'sd1; bm[i][j] = 8'sd1; end
        run_job(0);
        if (obs_a[0][DW-1:0] !== 8'hFF) begin $display("FAIL signed_laneFF got %h want ff", obs_a[0][DW-1:0]); errors++; end
        checks++;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (obs_c[i][j] !== 16'hFFFC) begin $display("FAIL signed_m1_c[%0d][%0d] got %h want fffc", i, j, obs_c[i][j]); errors++; end
                checks++;
            end
    endtask

    task automatic test_reset_mid_stream();
        randomize_ops();
        load_only(0);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        if (ifc.a_out[3*DW +: DW] !== am[3][0] || ifc.busy !== 1'b1) begin
            $display("FAIL midrst_pre c=3 lane3 got %h busy %b want %h 1", ifc.a_out[3*DW +: DW], ifc.busy, am[3][0]); errors++;
        end
        checks++;
        rst = 1'b0;
        #1;
        if (ifc.a_out !== '0 || ifc.b_out !== '0 || ifc.busy !== 1'b0) begin
            $display("FAIL midrst_async got a=%h b=%h busy=%b want 0 0 0", ifc.a_out, ifc.b_out, ifc.busy); errors++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if (ifc.a_out !== '0 || ifc.b_out !== '0 || ifc.in_ready !== 1'b1 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            $display("FAIL midrst_after got a=%h b=%h rdy=%b busy=%b done=%b want 0 0 1 0 0",
                     ifc.a_out, ifc.b_out, ifc.in_ready, ifc.busy, ifc.done); errors++;
        end
        checks++;
        randomize_ops();
        compute_exp();
        run_job(0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (obs_c[i][j] !== exp_c[i][j]) begin
                    $display("FAIL midrst_c[%0d][%0d] got %h want %h", i, j, obs_c[i][j], exp_c[i][j]); errors++;
                end
                checks++;
            end
        if (done_t !== 12) begin $display("FAIL midrst_done_lat got %0d want 12", done_t); errors++; end
        checks++;
    endtask

    task automatic test_random();
        for (int job = 0; job < 3; job++) begin
            randomize_ops();
            compute_exp();
            run_job(0);
            for (int c = 0; c < NC; c++)
                for (int l = 0; l < N; l++) begin
                    if (obs_a[c][l*DW +: DW] !== exp_a_lane(c, l) || obs_b[c][l*DW +: DW] !== exp_b_lane(c, l)) begin
                        $display("FAIL rand_stream job %0d c=%0d lane %0d got a=%h b=%h want a=%h b=%h", job, c, l,
                                 obs_a[c][l*DW +: DW], obs_b[c][l*DW +: DW], exp_a_lane(c, l), exp_b_lane(c, l));
                        errors++;
                    end
                    checks++;
                end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    if (obs_c[i][j] !== exp_c[i][j]) begin
                        $display("FAIL rand_c job %0d [%0d][%0d] got %h want %h", job, i, j, obs_c[i][j], exp_c[i][j]); errors++;
                    end
                    checks++;
                end
            $display("job %0d: done at cycle %0d, C[0][0]=%h", job, done_t, obs_c[0][0]);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_gapped();
        test_held_valid();
        test_back_to_back();
        test_signed();
        test_reset_mid_stream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
